exec_wb_stage: RTL and testbench
================================

Name: exec_wb_stage

Overview:
- Execute/writeback stage directly upstream of the register file.
- Consumes the two source operands read from the register file, a decoded opcode, a destination index and an immediate.
- Produces the registered write port: destination, write enable and write data.
- Single-cycle ALU ops plus an iterative shift-add multiply, with a valid/ready handshake toward the decoder.

Parameters:
- DATA_W, 8, operand/result width in bits.
- RD_W, 3, destination register index width (8 registers).

Ports:
- clka  input  1  single clock, all state on posedge.
- reset_in  input  1  asynchronous, active-low reset.
- valid_in  input  1  decoder presents a valid op this cycle.
- ready_out  output  1  stage can accept an op this cycle.
- op_in  input  4  opcode.
- rd_in  input  RD_W  destination register index.
- sr1_data_in  input  DATA_W  operand A (register file sr1 read).
- sr2_data_in  input  DATA_W  operand B (register file sr2 read).
- imm_in  input  DATA_W  immediate for LDI.
- rd_out  output  RD_W  writeback destination.
- we_reg_out  output  1  writeback strobe, one-cycle pulse.
- data_out  output  DATA_W  writeback data.
- zero_flag_out  output  1  result == 0 of last committed op.
- carry_flag_out  output  1  carry/borrow/shift-out of last committed op.
- illegal_out  output  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (reset_in=0, async):
  - State goes to IDLE.
  - rd_out=0, data_out=0, we_reg_out=0, zero_flag_out=0, carry_flag_out=0, illegal_out=0, ready_out=1.
  - Multiply registers are cleared. Reset mid-multiply aborts with no writeback.
- Accept: an op is accepted on a posedge where valid_in=1 and ready_out=1. Operands are sampled at that edge only.
- ready_out=1 in IDLE, 0 in MUL. It is a function of state only, with no combinational path from valid_in.
- Opcodes:
  - 0 ADD: A+B, carry = bit DATA_W.
  - 1 SUB: A-B, carry = borrow (A<B).
  - 2 AND. 3 OR. 4 XOR. 5 NOT A. For opcodes 2–5, carry=0.
  - 6 SHL A by 1: carry = A[MSB].
  - 7 SHR A by 1, logical: carry = A[0].
  - 8 MOV: B, carry=0.
  - 9 LDI: imm_in, carry=0.
  - A MUL: low DATA_W bits of A*B, carry = 1 if the high half is nonzero.
  - B–F: illegal.
- Single-cycle ops:
  - Accepted at edge N. At edge N+1 (visible after N): we_reg_out=1, rd_out=rd_in, data_out=result, flags updated.
  - we_reg_out returns to 0 the next cycle unless another op is accepted.
  - Back-to-back accepts give one writeback per cycle.
- MUL:
  - IDLE -> MUL on accept. Multiplicand, multiplier and rd are latched; the accumulator is cleared.
  - MUL iterates DATA_W cycles, one multiplier bit per cycle, LSB first, with a 2*DATA_W accumulator.
  - After the last iteration: -> IDLE, with we_reg_out=1 and data/flags committed.
  - Accept at edge N gives writeback visible after edge N+DATA_W (8).
  - valid_in is ignored while in MUL.
- Illegal op: accepted, then illegal_out=1 for one cycle. we_reg_out=0. rd_out, data_out and flags hold.
- data_out, rd_out and flags hold their last values between writebacks.
- rd_out=0 is a legal destination. No special-casing.
- All arithmetic is modulo 2^DATA_W. Carry is computed at DATA_W+1 bits.

Optional Feature:
- Macro EXEC_MUL_EN.
- Defined: opcode A behaves as MUL above.
- Undefined:
  - The MUL state and multiply datapath are not compiled.
  - Opcode A is treated as illegal (illegal_out pulse, no write).
  - ready_out is constant 1.

Test Plan:
- Reset then release -> all outputs 0, ready_out=1. Assert reset_in=0 while in MUL (EXEC_MUL_EN) -> no we_reg_out pulse, ready_out=1 immediately.
- ADD A=8'hF0, B=8'h20, rd=3 -> next cycle we_reg_out=1, rd_out=3, data_out=8'h10, carry=1, zero=0. SUB 5-5 -> data_out=0, zero=1, carry=0.
- Back-to-back: LDI imm=8'h5A rd=1, then SHL A=8'h81 rd=2, then SHR A=8'h01 rd=7 -> three consecutive writebacks:
  - 5A/1, carry 0.
  - 02/2, carry 1.
  - 00/7, zero 1, carry 1.
- MUL A=8'h0C, B=8'h0B, rd=4 (EXEC_MUL_EN) -> ready_out=0 for 8 cycles, valid_in held high with other ops ignored, then data_out=8'h84, carry=0. Then MUL 8'h10*8'h10 -> data_out=0, zero=1, carry=1.
- Opcode F, then opcode A with EXEC_MUL_EN undefined -> illegal_out pulses, we_reg_out stays 0, data_out and flags unchanged from the prior op.

Source files
------------

// File: rtl/exec_wb_stage_if.sv
// ---------------------------------------------------------------------------
// exec_wb_stage_if
//   Bundle of the decoder-facing handshake, operand inputs and the
//   register-file writeback outputs of the execute/writeback stage.
//
//   Parameters:
//     DATA_W : operand/result width in bits
//     RD_W   : destination register index width
//
//   Signals (directions seen from the stage, i.e. the slave modport):
//     valid_in        in   decoder presents a valid op
//     ready_out       out  stage can accept an op this cycle
//     op_in           in   4-bit opcode
//     rd_in           in   destination register index
//     sr1_data_in     in   operand A
//     sr2_data_in     in   operand B
//     imm_in          in   immediate for LDI
//     rd_out          out  writeback destination
//     we_reg_out      out  writeback strobe (one-cycle pulse)
//     data_out        out  writeback data
//     zero_flag_out   out  result == 0 of last committed op
//     carry_flag_out  out  carry/borrow/shift-out of last committed op
//     illegal_out     out  one-cycle pulse on an undefined opcode
//
//   Modports:
//     master : decoder / register-file side
//     slave  : the execute/writeback stage
// ---------------------------------------------------------------------------
interface exec_wb_stage_if #(
  parameter int DATA_W = 8,
  parameter int RD_W   = 3
);

  logic              valid_in;
  logic              ready_out;
  logic [3:0]        op_in;
  logic [RD_W-1:0]   rd_in;
  logic [DATA_W-1:0] sr1_data_in;
  logic [DATA_W-1:0] sr2_data_in;
  logic [DATA_W-1:0] imm_in;
  logic [RD_W-1:0]   rd_out;
  logic              we_reg_out;
  logic [DATA_W-1:0] data_out;
  logic              zero_flag_out;
  logic              carry_flag_out;
  logic              illegal_out;

  modport master (
    output valid_in, op_in, rd_in, sr1_data_in, sr2_data_in, imm_in,
    input  ready_out, rd_out, we_reg_out, data_out,
           zero_flag_out, carry_flag_out, illegal_out
  );

  modport slave (
    input  valid_in, op_in, rd_in, sr1_data_in, sr2_data_in, imm_in,
    output ready_out, rd_out, we_reg_out, data_out,
           zero_flag_out, carry_flag_out, illegal_out
  );

endinterface

// File: rtl/exec_wb_stage.sv
// ---------------------------------------------------------------------------
// exec_wb_stage
//   Execute/writeback stage sitting directly upstream of the register file.
//   Single-cycle ALU ops are committed one edge after they are accepted.
//   When EXEC_MUL_EN is defined, opcode 0xA runs an iterative shift-add
//   multiply (one multiplier bit per cycle, LSB first) and commits DATA_W
//   edges after acceptance; otherwise opcode 0xA is illegal and the stage
//   is always ready.
//
//   Configuration macro: EXEC_MUL_EN (enables the multiply state/datapath)
//
//   Ports:
//     clka      : clock, all state updates on posedge
//     reset_in  : asynchronous, active-low reset
//     bus       : exec_wb_stage_if.slave (handshake, operands, writeback)
// ---------------------------------------------------------------------------
module exec_wb_stage #(
  parameter int DATA_W = 8,
  parameter int RD_W   = 3
) (
  input  logic           clka,
  input  logic           reset_in,
  exec_wb_stage_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam int         CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t                state_q,  state_nxt;
  logic [2*DATA_W-1:0]   mcand_q,  mcand_nxt;
  logic [DATA_W-1:0]     mplier_q, mplier_nxt;
  logic [2*DATA_W-1:0]   acc_q,    acc_nxt;
  logic [2*DATA_W-1:0]   acc_step;
  logic [CNT_W-1:0]      cnt_q,    cnt_nxt;
  logic [RD_W-1:0]       mul_rd_q, mul_rd_nxt;
  logic                  alu_is_mul;
`endif

  logic                  ready;
  logic                  accept;

  logic [DATA_W:0]       sum_ext;
  logic [DATA_W:0]       diff_ext;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_carry;
  logic                  alu_illegal;

  logic [RD_W-1:0]       rd_q,      rd_nxt;
  logic [DATA_W-1:0]     data_q,    data_nxt;
  logic                  we_q,      we_nxt;
  logic                  zero_q,    zero_nxt;
  logic                  carry_q,   carry_nxt;
  logic                  illegal_q, illegal_nxt;

  // Ready depends only on the registered state so the decoder never sees a
  // combinational loop back through valid_in.
`ifdef EXEC_MUL_EN
  assign ready = (state_q == IDLE);
`else
  assign ready = 1'b1;
`endif
  assign accept = bus.valid_in & ready;

  // Extended add/subtract so bit DATA_W carries the carry-out or borrow.
  assign sum_ext  = {1'b0, bus.sr1_data_in} + {1'b0, bus.sr2_data_in};
  assign diff_ext = {1'b0, bus.sr1_data_in} - {1'b0, bus.sr2_data_in};

  // Single-cycle ALU: decode the opcode into a result, its carry, and a flag
  // saying whether the op is undefined (or, with the multiplier built in,
  // whether it has to be handed off to the iterative multiply).
  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
`ifdef EXEC_MUL_EN
    alu_is_mul  = 1'b0;
`endif
    case (bus.op_in)
      OP_ADD: begin
        alu_res   = sum_ext[DATA_W-1:0];
        alu_carry = sum_ext[DATA_W];
      end
      OP_SUB: begin
        alu_res   = diff_ext[DATA_W-1:0];
        alu_carry = diff_ext[DATA_W];
      end
      OP_AND: alu_res = bus.sr1_data_in & bus.sr2_data_in;
      OP_OR:  alu_res = bus.sr1_data_in | bus.sr2_data_in;
      OP_XOR: alu_res = bus.sr1_data_in ^ bus.sr2_data_in;
      OP_NOT: alu_res = ~bus.sr1_data_in;
      OP_SHL: begin
        alu_res   = {bus.sr1_data_in[DATA_W-2:0], 1'b0};
        alu_carry = bus.sr1_data_in[DATA_W-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, bus.sr1_data_in[DATA_W-1:1]};
        alu_carry = bus.sr1_data_in[0];
      end
      OP_MOV: alu_res = bus.sr2_data_in;
      OP_LDI: alu_res = bus.imm_in;
`ifdef EXEC_MUL_EN
      OP_MUL: alu_is_mul = 1'b1;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

  // Next-state and next-output logic. Every register holds by default and
  // the writeback/illegal strobes default low so they only pulse for one
  // cycle. In MUL the stage ignores valid_in and steps the shift-add
  // multiply; the final step commits the low half and flags a carry when
  // any bit of the high half is set.
  always_comb begin
    rd_nxt      = rd_q;
    data_nxt    = data_q;
    zero_nxt    = zero_q;
    carry_nxt   = carry_q;
    we_nxt      = 1'b0;
    illegal_nxt = 1'b0;
`ifdef EXEC_MUL_EN
    state_nxt   = state_q;
    mcand_nxt   = mcand_q;
    mplier_nxt  = mplier_q;
    acc_nxt     = acc_q;
    cnt_nxt     = cnt_q;
    mul_rd_nxt  = mul_rd_q;
    acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);

    if (state_q == MUL) begin
      acc_nxt    = acc_step;
      mcand_nxt  = {mcand_q[2*DATA_W-2:0], 1'b0};
      mplier_nxt = {1'b0, mplier_q[DATA_W-1:1]};
      cnt_nxt    = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        state_nxt = IDLE;
        we_nxt    = 1'b1;
        rd_nxt    = mul_rd_q;
        data_nxt  = acc_step[DATA_W-1:0];
        zero_nxt  = (acc_step[DATA_W-1:0] == '0);
        carry_nxt = |acc_step[2*DATA_W-1:DATA_W];
      end
    end else
`endif
    if (accept) begin
`ifdef EXEC_MUL_EN
      if (alu_is_mul) begin
        state_nxt  = MUL;
        mcand_nxt  = {{DATA_W{1'b0}}, bus.sr1_data_in};
        mplier_nxt = bus.sr2_data_in;
        acc_nxt    = '0;
        cnt_nxt    = '0;
        mul_rd_nxt = bus.rd_in;
      end else
`endif
      if (alu_illegal) begin
        illegal_nxt = 1'b1;
      end else begin
        we_nxt    = 1'b1;
        rd_nxt    = bus.rd_in;
        data_nxt  = alu_res;
        zero_nxt  = (alu_res == '0);
        carry_nxt = alu_carry;
      end
    end
  end

  // State and output registers. Reset is asynchronous so asserting it in the
  // middle of a multiply drops the operation without any writeback.
  always_ff @(posedge clka or negedge reset_in) begin
    if (!reset_in) begin
      rd_q      <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      rd_q      <= rd_nxt;
      data_q    <= data_nxt;
      we_q      <= we_nxt;
      zero_q    <= zero_nxt;
      carry_q   <= carry_nxt;
      illegal_q <= illegal_nxt;
    end
  end

`ifdef EXEC_MUL_EN
  // FSM state plus the multiply working registers.
  always_ff @(posedge clka or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_rd_q <= '0;
    end else begin
      state_q  <= state_nxt;
      mcand_q  <= mcand_nxt;
      mplier_q <= mplier_nxt;
      acc_q    <= acc_nxt;
      cnt_q    <= cnt_nxt;
      mul_rd_q <= mul_rd_nxt;
    end
  end
`endif

  assign bus.ready_out      = ready;
  assign bus.rd_out         = rd_q;
  assign bus.data_out       = data_q;
  assign bus.we_reg_out     = we_q;
  assign bus.zero_flag_out  = zero_q;
  assign bus.carry_flag_out = carry_q;
  assign bus.illegal_out    = illegal_q;

endmodule

// File: tb/tb_exec_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_exec_wb_stage
//   Directed-vector bench for exec_wb_stage. Expected values are worked out
//   by hand for each vector. Honours EXEC_MUL_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_exec_wb_stage;

  localparam int DATA_W = 8;
  localparam int RD_W   = 3;

  logic clka = 1'b0;
  logic reset_in;
  int   vectors     = 0;
  int   miscompares = 0;

  exec_wb_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  exec_wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clka     (clka),
    .reset_in (reset_in),
    .bus      (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clka = ~clka;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one op on the falling edge, let the rising edge take it, then
  // step just past the edge so registered outputs can be sampled.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] imm);
    @(negedge clka);
    bus.valid_in    = 1'b1;
    bus.op_in       = op;
    bus.rd_in       = rd;
    bus.sr1_data_in = a;
    bus.sr2_data_in = b;
    bus.imm_in      = imm;
    @(posedge clka);
    #1;
    bus.valid_in    = 1'b0;
  endtask

  // One clock with no valid op.
  task automatic idleCycle();
    @(negedge clka);
    bus.valid_in = 1'b0;
    @(posedge clka);
    #1;
  endtask

  // One clock with valid held high carrying an ADD that must be ignored.
  task automatic holdCycle();
    @(negedge clka);
    bus.valid_in    = 1'b1;
    bus.op_in       = 4'h0;
    bus.rd_in       = 3'd1;
    bus.sr1_data_in = 8'h01;
    bus.sr2_data_in = 8'h01;
    @(posedge clka);
    #1;
  endtask

  // A writeback is expected this cycle with the given contents.
  task automatic checkWrite(input string tag, input logic [2:0] rd,
                            input logic [7:0] data, input logic zero,
                            input logic carry);
    checkOutput({tag, "_we"},    16'(bus.we_reg_out),     16'h1);
    checkOutput({tag, "_rd"},    16'(bus.rd_out),         16'(rd));
    checkOutput({tag, "_data"},  16'(bus.data_out),       16'(data));
    checkOutput({tag, "_zero"},  16'(bus.zero_flag_out),  16'(zero));
    checkOutput({tag, "_carry"}, 16'(bus.carry_flag_out), 16'(carry));
    checkOutput({tag, "_ill"},   16'(bus.illegal_out),    16'h0);
  endtask

  // An illegal-opcode pulse with all writeback state holding.
  task automatic checkIllegal(input string tag, input logic [2:0] rd,
                              input logic [7:0] data, input logic zero,
                              input logic carry);
    checkOutput({tag, "_ill"},   16'(bus.illegal_out),    16'h1);
    checkOutput({tag, "_we"},    16'(bus.we_reg_out),     16'h0);
    checkOutput({tag, "_rd"},    16'(bus.rd_out),         16'(rd));
    checkOutput({tag, "_data"},  16'(bus.data_out),       16'(data));
    checkOutput({tag, "_zero"},  16'(bus.zero_flag_out),  16'(zero));
    checkOutput({tag, "_carry"}, 16'(bus.carry_flag_out), 16'(carry));
  endtask

  // Directed sequence.
  initial begin
    bus.valid_in    = 1'b0;
    bus.op_in       = '0;
    bus.rd_in       = '0;
    bus.sr1_data_in = '0;
    bus.sr2_data_in = '0;
    bus.imm_in      = '0;
    reset_in        = 1'b0;

    #12;
    checkOutput("rst_rd",    16'(bus.rd_out),         16'h0);
    checkOutput("rst_data",  16'(bus.data_out),       16'h0);
    checkOutput("rst_we",    16'(bus.we_reg_out),     16'h0);
    checkOutput("rst_zero",  16'(bus.zero_flag_out),  16'h0);
    checkOutput("rst_carry", 16'(bus.carry_flag_out), 16'h0);
    checkOutput("rst_ill",   16'(bus.illegal_out),    16'h0);
    checkOutput("rst_ready", 16'(bus.ready_out),      16'h1);
    @(negedge clka);
    reset_in = 1'b1;
    idleCycle();
    checkOutput("post_rst_we",    16'(bus.we_reg_out), 16'h0);
    checkOutput("post_rst_ready", 16'(bus.ready_out),  16'h1);

    // ADD F0+20 = 0x110 -> 0x10 with carry out
    applyStimulus(4'h0, 3'd3, 8'hF0, 8'h20, 8'h00);
    checkWrite("add", 3'd3, 8'h10, 1'b0, 1'b1);
    idleCycle();
    checkOutput("hold_we",   16'(bus.we_reg_out), 16'h0);
    checkOutput("hold_data", 16'(bus.data_out),   16'h10);
    checkOutput("hold_rd",   16'(bus.rd_out),     16'h3);

    applyStimulus(4'h1, 3'd6, 8'h05, 8'h05, 8'h00);
    checkWrite("sub_eq", 3'd6, 8'h00, 1'b1, 1'b0);
    applyStimulus(4'h1, 3'd2, 8'h03, 8'h05, 8'h00);
    checkWrite("sub_borrow", 3'd2, 8'hFE, 1'b0, 1'b1);
    applyStimulus(4'h0, 3'd0, 8'h80, 8'h80, 8'h00);
    checkWrite("add_wrap_rd0", 3'd0, 8'h00, 1'b1, 1'b1);
    applyStimulus(4'h2, 3'd2, 8'hC3, 8'h0F, 8'h00);
    checkWrite("and", 3'd2, 8'h03, 1'b0, 1'b0);
    applyStimulus(4'h3, 3'd3, 8'hC0, 8'h0C, 8'h00);
    checkWrite("or", 3'd3, 8'hCC, 1'b0, 1'b0);
    applyStimulus(4'h4, 3'd4, 8'hA5, 8'hFF, 8'h00);
    checkWrite("xor", 3'd4, 8'h5A, 1'b0, 1'b0);
    applyStimulus(4'h5, 3'd5, 8'h0F, 8'h00, 8'h00);
    checkWrite("not", 3'd5, 8'hF0, 1'b0, 1'b0);
    applyStimulus(4'h8, 3'd6, 8'h11, 8'h77, 8'h00);
    checkWrite("mov", 3'd6, 8'h77, 1'b0, 1'b0);

    // Back-to-back: one writeback per cycle
    applyStimulus(4'h9, 3'd1, 8'h00, 8'h00, 8'h5A);
    checkWrite("b2b_ldi", 3'd1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(4'h6, 3'd2, 8'h81, 8'h00, 8'h00);
    checkWrite("b2b_shl", 3'd2, 8'h02, 1'b0, 1'b1);
    applyStimulus(4'h7, 3'd7, 8'h01, 8'h00, 8'h00);
    checkWrite("b2b_shr", 3'd7, 8'h00, 1'b1, 1'b1);

    // Illegal opcode F: pulse, nothing written, previous SHR result holds
    applyStimulus(4'hF, 3'd5, 8'h33, 8'h44, 8'h55);
    checkIllegal("ill_f", 3'd7, 8'h00, 1'b1, 1'b1);
    idleCycle();
    checkOutput("ill_f_end", 16'(bus.illegal_out), 16'h0);

`ifdef EXEC_MUL_EN
    // MUL 0C*0B = 0x84, committed 8 edges after acceptance
    applyStimulus(4'hA, 3'd4, 8'h0C, 8'h0B, 8'h00);
    checkOutput("mul_ready0", 16'(bus.ready_out),  16'h0);
    checkOutput("mul_we0",    16'(bus.we_reg_out), 16'h0);
    for (int i = 1; i < 8; i++) begin
      holdCycle();
      checkOutput($sformatf("mul_busy%0d_ready", i), 16'(bus.ready_out),  16'h0);
      checkOutput($sformatf("mul_busy%0d_we", i),    16'(bus.we_reg_out), 16'h0);
    end
    holdCycle();
    checkWrite("mul_0c_0b", 3'd4, 8'h84, 1'b0, 1'b0);
    checkOutput("mul_done_ready", 16'(bus.ready_out), 16'h1);

    // MUL 10*10 = 0x100: low half zero, high half nonzero
    applyStimulus(4'hA, 3'd5, 8'h10, 8'h10, 8'h00);
    for (int i = 1; i < 8; i++) idleCycle();
    checkOutput("mul2_we_early", 16'(bus.we_reg_out), 16'h0);
    idleCycle();
    checkWrite("mul_10_10", 3'd5, 8'h00, 1'b1, 1'b1);

    // Reset in the middle of a multiply aborts it with no writeback
    applyStimulus(4'hA, 3'd6, 8'hFF, 8'hFF, 8'h00);
    idleCycle();
    idleCycle();
    idleCycle();
    reset_in = 1'b0;
    #1;
    checkOutput("abort_ready", 16'(bus.ready_out),  16'h1);
    checkOutput("abort_we",    16'(bus.we_reg_out), 16'h0);
    checkOutput("abort_data",  16'(bus.data_out),   16'h0);
    @(negedge clka);
    reset_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idleCycle();
      checkOutput($sformatf("abort_quiet%0d_we", i), 16'(bus.we_reg_out), 16'h0);
    end
    checkOutput("abort_end_ready", 16'(bus.ready_out), 16'h1);
`else
    // Without the multiplier, opcode A is just another illegal opcode
    applyStimulus(4'hA, 3'd4, 8'h0C, 8'h0B, 8'h00);
    checkIllegal("ill_a", 3'd7, 8'h00, 1'b1, 1'b1);
    checkOutput("ill_a_ready", 16'(bus.ready_out), 16'h1);
    idleCycle();
    checkOutput("ill_a_end", 16'(bus.illegal_out), 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
